uart_rx_deframer: RTL and testbench

Receive-side framing engine of the full-duplex UART IP core. Sits directly downstream of the receive baud generator: it consumes the generator's single-cycle oversampling tick and the asynchronous serial line, recovers 8N1 / 8E1 / 8O1 frames by mid-bit sampling, and presents each byte with its error flags in a one-entry holding register behind a valid/ready handshake. It is rate-agnostic; baud selection lives entirely in the generator.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 42 ++++
 rtl/uart_rx_deframer.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   - uart_state_e     : deframer/framer state encoding
//   - UART_DATA_BITS   : default payload width
//   - UART_OVERSAMPLE  : default baud ticks per bit period
//   - parity_expected(): parity bit a well-formed frame must carry
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Even parity makes the total number of ones even, so the parity bit equals
  // the XOR of the payload; odd parity inverts it.
  function automatic logic parity_expected(input logic data_xor, input logic odd);
    return data_xor ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: multi-flop synchronizer for an asynchronous input followed by
// an enable-gated edge-detect flop.
//   clk, rst : system clock, synchronous active-high reset (flops load 1)
//   en       : edge-detect flop advances only when en = 1
//   d        : asynchronous input, idle high
//   rxs      : synchronized input
//   fall     : previous enabled sample was 1 and current synchronized value is 0
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic rxs,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  always_comb begin
    // Shift d in at the bottom; the oldest stage drops off the top.
    sync_d = SYNC_STAGES'({sync_q, d});
    // Gated by the baud tick so a fall persists until the FSM next looks at it.
    edge_d = en ? sync_q[SYNC_STAGES-1] : edge_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      edge_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign fall = edge_q & ~rxs;

endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: recovers 8N1/8E1/8O1 frames by mid-bit sampling on the
// oversampling baud tick and holds each byte in a one-entry register.
//   clk, rst            : system clock, synchronous active-high reset
//   baud_tick           : one-clk enable at OVERSAMPLE x baud
//   rx                  : asynchronous serial line, idle high
//   parity_en/odd       : frame carries parity / parity is odd
//   rx_ready            : consumer accepts the held byte
//   rx_data, rx_valid   : held byte and holding-register-full flag
//   parity_err, frame_err : error flags describing the held byte
//   overrun             : sticky, a completed frame was dropped
//   busy                : receiver not idle
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rxs, fall;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .en   (baud_tick),
    .d    (rx),
    .rxs  (rxs),
    .fall (fall)
  );

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_acc_q, par_acc_d;    // running XOR of payload
  logic                 perr_fr_q, perr_fr_d;    // parity verdict of frame in flight
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 commit, hs;

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_acc_d    = par_acc_q;
    perr_fr_d    = perr_fr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    commit       = 1'b0;
    hs           = rx_valid_q & rx_ready;

    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (fall) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end
        START: begin
          if (tick_cnt_q == HALF_M1) begin
            tick_cnt_d = '0;
            if (!rxs) begin
              state_d   = DATA;
              bit_idx_d = '0;
              par_acc_d = 1'b0;
              perr_fr_d = 1'b0;
            end else begin
              // Line was high again at mid start bit: a glitch, not a frame.
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d       = '0;
            shift_d[bit_idx_q] = rxs;
            par_acc_d        = par_acc_q ^ rxs;
            if (bit_idx_q == LAST_BIT) begin
              bit_idx_d = '0;
              state_d   = parity_en ? PARITY : STOP;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            perr_fr_d  = rxs != parity_expected(par_acc_q, parity_odd);
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            commit     = 1'b1;
            // Back to IDLE at mid stop bit so a following start edge is caught.
            state_d    = IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Holding register: a commit wins over a plain handshake; a commit into a
    // full, unaccepted register drops the frame and records the overrun.
    if (commit) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_d;
        parity_err_d = perr_fr_q;
        frame_err_d  = ~rxs;
        rx_valid_d   = 1'b1;
        if (hs) overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (hs) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_acc_q    <= 1'b0;
      perr_fr_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_acc_q    <= par_acc_d;
      perr_fr_q    <= perr_fr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: directed serial frames, a queue of expected
// deliveries built from the framing rules, one compare process on every clock,
// and literal spot checks of the held byte and flags.
module tb_uart_rx_deframer;

  localparam int TICK_DIV = 4;               // clk per baud tick
  localparam int BIT_CLK  = 16 * TICK_DIV;   // clk per bit period

  logic       clk = 1'b0;
  logic       rst, baud_tick, rx, parity_en, parity_odd, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, busy;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;
  int   n_deliv = 0;
  int   vld_cycles = 0;
  int   base;

  uart_rx_deframer dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_gen();
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  endtask

  // Expected delivery derived from the frame contents alone.
  task automatic push_exp(input logic [7:0] d, input logic pen, input logic odd,
                          input logic pbit, input logic stopb);
    exp_t e;
    e.d  = d;
    e.pe = pen ? (pbit != ((^d) ^ odd)) : 1'b0;
    e.fe = ~stopb;
    exp_q.push_back(e);
  endtask

  task automatic bit_period(input logic b);
    rx = b;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stopb);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(d[i]);
    if (pen) bit_period(pbit);
    bit_period(stopb);
  endtask

  // A delivery is rx_valid high when the previous cycle did not hold an
  // unaccepted byte; it must match the head of the expected queue. Otherwise
  // a held byte must remain the last delivered one.
  task automatic monitor();
    logic pv, pr;
    exp_t e;
    pv = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        vld_cycles++;
        if (!(pv && !pr)) begin
          n_deliv++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_delivery: got data %0h, expected no delivery", rx_data);
          end else begin
            e = exp_q.pop_front();
            chk("deliv_data", 32'(rx_data), 32'(e.d));
            chk("deliv_perr", 32'(parity_err), 32'(e.pe));
            chk("deliv_ferr", 32'(frame_err), 32'(e.fe));
            last_exp = e;
          end
        end else begin
          chk("hold_data", 32'(rx_data), 32'(last_exp.d));
          chk("hold_flags", 32'({parity_err, frame_err}), 32'({last_exp.pe, last_exp.fe}));
        end
      end
      pv = (rx_valid === 1'b1);
      pr = (rx_ready === 1'b1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},    32'(rx_data),    32'h0);
    chk({tag, "_valid"},   32'(rx_valid),   32'h0);
    chk({tag, "_perr"},    32'(parity_err), 32'h0);
    chk({tag, "_ferr"},    32'(frame_err),  32'h0);
    chk({tag, "_overrun"}, 32'(overrun),    32'h0);
    chk({tag, "_busy"},    32'(busy),       32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    baud_tick  = 1'b0;
    rx         = 1'b1;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    rx_ready   = 1'b1;
    last_exp   = '0;
    wait_clk(4);
    chk_all_zero("reset");
    rst = 1'b0;
    fork
      monitor();
      tick_gen();
    join_none
    wait_clk(2 * BIT_CLK);

    // 8N1 0xA5, consumer always ready: one-cycle valid pulse
    base = vld_cycles;
    push_exp(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_clk(BIT_CLK);
    chk("a5_valid_cycles", 32'(vld_cycles - base), 32'd1);
    chk("a5_data", 32'(rx_data), 32'hA5);
    chk("a5_perr", 32'(parity_err), 32'h0);
    chk("a5_ferr", 32'(frame_err), 32'h0);

    // Parity: even with wrong bit, even with right bit, odd with right bit
    parity_en = 1'b1;
    parity_odd = 1'b0;
    push_exp(8'h03, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    wait_clk(BIT_CLK);
    chk("e03_bad_perr", 32'(parity_err), 32'h1);
    chk("e03_bad_data", 32'(rx_data), 32'h03);
    push_exp(8'h03, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1);
    wait_clk(BIT_CLK);
    chk("e03_ok_perr", 32'(parity_err), 32'h0);
    parity_odd = 1'b1;
    push_exp(8'h03, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    wait_clk(BIT_CLK);
    chk("o03_perr", 32'(parity_err), 32'h0);
    parity_en = 1'b0;
    parity_odd = 1'b0;

    // 4-tick low glitch on an idle line
    base = n_deliv;
    rx = 1'b0;
    wait_clk(4 * TICK_DIV);
    chk("glitch_busy_high", 32'(busy), 32'h1);
    rx = 1'b1;
    wait_clk(8 * TICK_DIV);
    chk("glitch_busy_low", 32'(busy), 32'h0);
    wait_clk(BIT_CLK);
    chk("glitch_no_delivery", 32'(n_deliv - base), 32'd0);

    // Stop bit low then break for three frame times
    base = n_deliv;
    push_exp(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    wait_clk(30 * BIT_CLK);
    rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    chk("break_single_delivery", 32'(n_deliv - base), 32'd1);
    chk("break_data", 32'(rx_data), 32'h55);
    chk("break_ferr", 32'(frame_err), 32'h1);
    push_exp(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    wait_clk(BIT_CLK);
    chk("after_break_data", 32'(rx_data), 32'h5A);
    chk("after_break_ferr", 32'(frame_err), 32'h0);

    // Back-to-back frames with consumer stalled: second frame dropped
    rx_ready = 1'b0;
    push_exp(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    wait_clk(BIT_CLK);
    chk("ovr_valid", 32'(rx_valid), 32'h1);
    chk("ovr_data", 32'(rx_data), 32'h11);
    chk("ovr_flag", 32'(overrun), 32'h1);
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    wait_clk(1);
    chk("ovr_pulse_valid", 32'(rx_valid), 32'h0);
    chk("ovr_pulse_flag", 32'(overrun), 32'h0);
    rx_ready = 1'b1;

    // Reset in the middle of bit 4 of 0xF0
    bit_period(1'b0);
    for (int i = 0; i < 4; i++) bit_period(1'b0);
    rx = 1'b1;
    wait_clk(BIT_CLK / 2);
    chk("mid_frame_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    wait_clk(1);
    chk_all_zero("midrst");
    rst = 1'b0;
    wait_clk(2 * BIT_CLK);
    push_exp(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    wait_clk(BIT_CLK);
    chk("post_rst_data", 32'(rx_data), 32'h3C);
    chk("post_rst_ferr", 32'(frame_err), 32'h0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
